// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Initiator-side controller for the 32-bit structural ALU.
//             Accepts one operation over a valid/ready request handshake and
//             drives the ALU operand/command lines from registers. It then
//             waits SETTLE_CYCLES clocks for the ripple path to resolve,
//             captures result and flags, and returns them over a valid/ready
//             response handshake.
//  Ports    :
//    clk, reset                       rising-edge clock, async active-high reset
//    req_valid/req_ready              request handshake
//    req_a, req_b, req_cmd            operands and 3-bit ALU command
//    alu_operandA/B, alu_command      registered drive to the ALU
//    alu_result, alu_carryout,
//    alu_zero, alu_overflow           ALU outputs, sampled at end of settle
//    resp_valid/resp_ready            response handshake
//    resp_result, resp_carryout,
//    resp_zero, resp_overflow         captured ALU outputs
//    busy                             high while an operation is in flight
//    op_count                         retired-response counter (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 4,   // legal range 1..255
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [2:0]        req_cmd,
    output logic [31:0]       alu_operandA,
    output logic [31:0]       alu_operandB,
    output logic [2:0]        alu_command,
    input  logic [31:0]       alu_result,
    input  logic              alu_carryout,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_result,
    output logic              resp_carryout,
    output logic              resp_zero,
    output logic              resp_overflow,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SETTLE  = 2'd1;
    localparam logic [1:0] c_RESPOND = 2'd2;

    // Counter is loaded with SETTLE_CYCLES-1 on the accept edge and the
    // sample happens on the edge that finds it at zero, which places the
    // sample exactly SETTLE_CYCLES edges after accept.
    localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_settleCnt;
    logic [31:0]      r_aluOperandA;
    logic [31:0]      r_aluOperandB;
    logic [2:0]       r_aluCommand;
    logic [31:0]      r_respResult;
    logic             r_respCarryout;
    logic             r_respZero;
    logic             r_respOverflow;
    logic [CNT_W-1:0] r_opCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_settleCnt    <= '0;
            r_aluOperandA  <= '0;
            r_aluOperandB  <= '0;
            r_aluCommand   <= '0;
            r_respResult   <= '0;
            r_respCarryout <= 1'b0;
            r_respZero     <= 1'b0;
            r_respOverflow <= 1'b0;
            r_opCount      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // req_ready is implied by being in IDLE.
                    if (req_valid) begin
                        r_aluOperandA <= req_a;
                        r_aluOperandB <= req_b;
                        r_aluCommand  <= req_cmd;
                        r_settleCnt   <= c_SETTLE_LOAD;
                        r_state       <= c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    if (r_settleCnt != 8'd0) begin
                        r_settleCnt <= r_settleCnt - 8'd1;
                    end else begin
                        r_respResult   <= alu_result;
                        r_respCarryout <= alu_carryout;
                        r_respZero     <= alu_zero;
                        r_respOverflow <= alu_overflow;
                        r_state        <= c_RESPOND;
                    end
                end
                c_RESPOND: begin
                    // Always return to IDLE: a new request cannot be taken in
                    // the same cycle a response retires.
                    if (resp_ready) begin
                        r_opCount <= r_opCount + 1'b1;
                        r_state   <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready     = (r_state == c_IDLE);
    assign busy          = (r_state != c_IDLE);
    assign resp_valid    = (r_state == c_RESPOND);
    assign alu_operandA  = r_aluOperandA;
    assign alu_operandB  = r_aluOperandB;
    assign alu_command   = r_aluCommand;
    assign resp_result   = r_respResult;
    assign resp_carryout = r_respCarryout;
    assign resp_zero     = r_respZero;
    assign resp_overflow = r_respOverflow;
    assign op_count      = r_opCount;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer. A behavioural ALU
//             model answers the DUT's ALU drive lines; expected responses are
//             computed from the request fields with plain arithmetic.
//             Built with CNT_W=4 so the operation counter wraps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int SETTLE = 4;
    localparam int CW     = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } aluOut_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_a;
    logic [31:0]   req_b;
    logic [2:0]    req_cmd;
    logic [31:0]   aluOpA;
    logic [31:0]   aluOpB;
    logic [2:0]    aluCmd;
    aluOut_t       aluStub;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_result;
    logic          resp_carryout;
    logic          resp_zero;
    logic          resp_overflow;
    logic          busy;
    logic [CW-1:0] op_count;

    int checks   = 0;
    int failures = 0;
    int expCount = 0;

    always #5 clk = ~clk;

    // Reference ALU behaviour from the command table.
    function automatic aluOut_t aluRef(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] cmd);
        aluOut_t     o;
        logic [32:0] sum;
        o = '0;
        case (cmd)
            3'b000: begin
                sum   = {1'b0, a} + {1'b0, b};
                o.res = sum[31:0];
                o.c   = sum[32];
                o.v   = (a[31] == b[31]) && (o.res[31] != a[31]);
            end
            3'b001: begin
                sum   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.res = sum[31:0];
                o.c   = sum[32];
                o.v   = (a[31] != b[31]) && (o.res[31] != a[31]);
            end
            3'b010: o.res = a ^ b;
            3'b011: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100: o.res = a & b;
            3'b101: o.res = ~(a & b);
            3'b110: o.res = ~(a | b);
            default: o.res = a | b;
        endcase
        o.z = (o.res == 32'd0);
        return o;
    endfunction

    always_comb aluStub = aluRef(aluOpA, aluOpB, aluCmd);

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cmd       (req_cmd),
        .alu_operandA  (aluOpA),
        .alu_operandB  (aluOpB),
        .alu_command   (aluCmd),
        .alu_result    (aluStub.res),
        .alu_carryout  (aluStub.c),
        .alu_zero      (aluStub.z),
        .alu_overflow  (aluStub.v),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_carryout (resp_carryout),
        .resp_zero     (resp_zero),
        .resp_overflow (resp_overflow),
        .busy          (busy),
        .op_count      (op_count)
    );

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called one step after an active edge with the DUT in IDLE. Runs one
    // full operation, holding the response for stallCycles before retiring.
    task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cmd, input aluOut_t exp, input int stallCycles);
        req_a     = a;
        req_b     = b;
        req_cmd   = cmd;
        req_valid = 1'b1;
        check({tag, ":reqReady"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;                         // accept edge N
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_cmd   = 3'($urandom);
        check({tag, ":aluA"},   64'(aluOpA), 64'(a));
        check({tag, ":aluB"},   64'(aluOpB), 64'(b));
        check({tag, ":aluCmd"}, 64'(aluCmd), 64'(cmd));
        check({tag, ":busy"},   64'(busy),   64'd1);
        for (int k = 1; k < SETTLE; k++) begin
            resp_ready = 1'($urandom_range(0, 1));  // must be ignored here
            check({tag, ":earlyValid"}, 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'($urandom_range(0, 1));
        check({tag, ":earlyValid"}, 64'(resp_valid), 64'd0);
        @(posedge clk); #1;                         // edge N+SETTLE
        resp_ready = 1'b0;
        check({tag, ":respValid"}, 64'(resp_valid),    64'd1);
        check({tag, ":result"},    64'(resp_result),   64'(exp.res));
        check({tag, ":carry"},     64'(resp_carryout), 64'(exp.c));
        check({tag, ":zero"},      64'(resp_zero),     64'(exp.z));
        check({tag, ":ovf"},       64'(resp_overflow), 64'(exp.v));
        check({tag, ":cntHeld"},   64'(op_count),      64'(expCount));
        for (int s = 0; s < stallCycles; s++) begin
            req_valid = 1'b1;
            req_a     = $urandom;
            @(posedge clk); #1;
            check({tag, ":stallValid"},  64'(resp_valid),  64'd1);
            check({tag, ":stallResult"}, 64'(resp_result), 64'(exp.res));
            check({tag, ":stallReqRdy"}, 64'(req_ready),   64'd0);
            check({tag, ":stallAluA"},   64'(aluOpA),      64'(a));
            check({tag, ":stallCnt"},    64'(op_count),    64'(expCount));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;                         // retire edge
        resp_ready = 1'b0;
        expCount   = (expCount + 1) % (1 << CW);
        check({tag, ":opCount"},    64'(op_count),   64'(expCount));
        check({tag, ":retValid"},   64'(resp_valid), 64'd0);
        check({tag, ":retReqRdy"},  64'(req_ready),  64'd1);
        check({tag, ":aluAHold"},   64'(aluOpA),     64'(a));
    endtask

    function automatic aluOut_t mk(input logic [31:0] r, input logic c,
                                   input logic z, input logic v);
        aluOut_t o;
        o.res = r; o.c = c; o.z = z; o.v = v;
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rc;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_cmd    = '0;
        resp_ready = 1'b0;
        #1;
        check("rst:reqReady", 64'(req_ready),  64'd1);
        check("rst:respValid", 64'(resp_valid), 64'd0);
        check("rst:busy",     64'(busy),       64'd0);
        check("rst:opCount",  64'(op_count),   64'd0);
        check("rst:aluA",     64'(aluOpA),     64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases with hand-derived expectations.
        doOp("add5p3",   32'd5,          32'd3, 3'b000, mk(32'd8,          1'b0, 1'b0, 1'b0), 0);
        doOp("sub0m1",   32'd0,          32'd1, 3'b001, mk(32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0), 0);
        doOp("addWrap",  32'hFFFF_FFFF,  32'd1, 3'b000, mk(32'd0,          1'b1, 1'b1, 1'b0), 1);
        doOp("addOvf",   32'h7FFF_FFFF,  32'd1, 3'b000, mk(32'h8000_0000,  1'b0, 1'b0, 1'b1), 0);
        doOp("sltNeg",   32'hFFFF_FFFE,  32'd3, 3'b011, mk(32'd1,          1'b0, 1'b0, 1'b0), 0);
        doOp("backpr",   32'h1234_5678,  32'h0F0F_0F0F, 3'b010,
             mk(32'h1D3B_5977, 1'b0, 1'b0, 1'b0), 10);

        // Reset in the middle of SETTLE, between clock edges.
        req_a = 32'hCAFE_0001; req_b = 32'd2; req_cmd = 3'b000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        expCount = 0;
        check("midRst:reqReady", 64'(req_ready),  64'd1);
        check("midRst:busy",     64'(busy),       64'd0);
        check("midRst:aluA",     64'(aluOpA),     64'd0);
        check("midRst:respValid", 64'(resp_valid), 64'd0);
        check("midRst:opCount",  64'(op_count),   64'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        doOp("postRst", 32'd100, 32'd58, 3'b001, mk(32'd42, 1'b1, 1'b0, 1'b0), 0);

        // Random operations; enough retires to wrap the 4-bit counter twice.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;           // exercise zero flag
            rc = 3'($urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                @(posedge clk); #1;
                check("idleGap", 64'(req_ready), 64'd1);
            end
            doOp("rand", ra, rb, rc, aluRef(ra, rb, rc), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
